// File: rtl/chnl_pkg.sv
// Types and helpers shared by the channel repacker and unpacker datapaths.
package chnl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chnl_state_t;

    typedef logic [31:0] chnl_cnt_t;

    // Buffer depth in words: one full input beat plus a partial output beat.
    function automatic int chnl_buff_words(input int n_in, input int n_out);
        return n_in + n_out - 1;
    endfunction

endpackage

// File: rtl/chnl_unpack_buf.sv
// Word buffer for the unpacker: appends k words at the fill point, shifts down
// by OUT words on a pop. Words at or above the fill count always read as 0.
module chnl_unpack_buf
    import chnl_pkg::*;
#(
    parameter int IN  = 8,
    parameter int OUT = 3,
    parameter int W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  chnl_cnt_t         push_k_i,
    input  logic [W*IN-1:0]   push_data_i,
    input  logic              pop_i,
    output chnl_cnt_t         v_o,
    output logic [W*OUT-1:0]  head_o
);

    localparam int BUFF = chnl_buff_words(IN, OUT);
    localparam int BW   = W * BUFF;

    logic [BW-1:0]   r_words;
    chnl_cnt_t       r_v;

    logic [W*IN-1:0] w_mask;
    logic [BW-1:0]   w_shifted;
    logic [BW-1:0]   w_ext;
    logic [BW-1:0]   w_placed;
    chnl_cnt_t       w_base;
    chnl_cnt_t       w_v_next;

    // Padding words are masked off so the zero-above-v invariant holds.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < IN; i++) begin
            if (chnl_cnt_t'(i) < push_k_i) begin
                w_mask[i*W +: W] = {W{1'b1}};
            end
        end
    end

    // Pop shift first, then the push lands at the post-shift fill point.
    assign w_shifted = pop_i ? (r_words >> (W * OUT)) : r_words;
    assign w_base    = pop_i ? (r_v - chnl_cnt_t'(OUT)) : r_v;
    assign w_ext     = BW'(push_data_i & w_mask);
    assign w_placed  = push_i ? (w_ext << (w_base * chnl_cnt_t'(W))) : '0;
    assign w_v_next  = r_v + (push_i ? push_k_i : '0) - (pop_i ? chnl_cnt_t'(OUT) : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_words <= '0;
            r_v     <= '0;
        end else begin
            r_words <= w_shifted | w_placed;
            r_v     <= w_v_next;
        end
    end

    assign v_o    = r_v;
    assign head_o = r_words[W*OUT-1:0];

endmodule

// File: rtl/chnl_unpacker.sv
// Host-to-device unpacker: wide IN-word host beats to narrow OUT-word beats,
// length-framed in output beats. Optional CHNL_UNPACKER_PAD_CNT_EN adds pad_cnt_o.
//
// Handshakes: a transfer happens on any cycle where val and rdy are both 1;
// no valid depends on its own rdy; in_rdy_o may depend on out_rdy_i.
module chnl_unpacker
    import chnl_pkg::*;
#(
    parameter int IN   = 8,
    parameter int OUT  = 3,
    parameter int W    = 8,
    parameter int LENW = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              len_val_i,
    input  logic [LENW-1:0]   len_i,
    output logic              len_rdy_o,
    input  logic              in_val_i,
    input  logic [W*IN-1:0]   in_data_i,
    output logic              in_rdy_o,
    output logic              out_val_o,
    output logic [W*OUT-1:0]  out_data_o,
    output logic              out_last_o,
    input  logic              out_rdy_i,
    output chnl_state_t       dbg_state_o
`ifdef CHNL_UNPACKER_PAD_CNT_EN
    ,
    output chnl_cnt_t         pad_cnt_o
`endif
);

    localparam int BUFF = chnl_buff_words(IN, OUT);

    chnl_state_t     r_state;
    chnl_state_t     w_state_next;
    logic [LENW-1:0] r_beats_left;
    logic [LENW-1:0] w_beats_left_next;
    chnl_cnt_t       r_words_left;
    chnl_cnt_t       w_words_left_next;

    chnl_cnt_t       w_v;
    chnl_cnt_t       w_k;
    logic            w_run;
    logic            w_pop;
    logic            w_push;
    logic [W*OUT-1:0] w_head;

    assign w_run      = (r_state == RUN);
    assign out_val_o  = w_run && (w_v >= chnl_cnt_t'(OUT));
    assign w_pop      = out_val_o && out_rdy_i;
    assign out_last_o = out_val_o && (r_beats_left == LENW'(1));
    assign len_rdy_o  = (r_state == IDLE);

    // Room check counts the words freed by a pop in the same cycle.
    assign in_rdy_o = w_run && (r_words_left != '0) &&
                      ((w_v + chnl_cnt_t'(IN)) <=
                       (chnl_cnt_t'(BUFF) + (w_pop ? chnl_cnt_t'(OUT) : '0)));
    assign w_push   = in_val_i && in_rdy_o;
    assign w_k      = (r_words_left < chnl_cnt_t'(IN)) ? r_words_left : chnl_cnt_t'(IN);

    assign out_data_o  = w_head;
    assign dbg_state_o = r_state;

    chnl_unpack_buf #(
        .IN  (IN),
        .OUT (OUT),
        .W   (W)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_k_i    (w_k),
        .push_data_i (in_data_i),
        .pop_i       (w_pop),
        .v_o         (w_v),
        .head_o      (w_head)
    );

    always_comb begin
        w_state_next      = r_state;
        w_beats_left_next = r_beats_left;
        w_words_left_next = r_words_left;
        case (r_state)
            IDLE: begin
                // A zero length completes the handshake but starts nothing.
                if (len_val_i && (len_i != '0)) begin
                    w_state_next      = RUN;
                    w_beats_left_next = len_i;
                    w_words_left_next = chnl_cnt_t'(len_i) * chnl_cnt_t'(OUT);
                end
            end
            RUN: begin
                if (w_push) begin
                    w_words_left_next = r_words_left - w_k;
                end
                if (w_pop) begin
                    w_beats_left_next = r_beats_left - LENW'(1);
                    if (r_beats_left == LENW'(1)) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_words_left <= '0;
        end else begin
            r_state      <= w_state_next;
            r_beats_left <= w_beats_left_next;
            r_words_left <= w_words_left_next;
        end
    end

`ifdef CHNL_UNPACKER_PAD_CNT_EN
    chnl_cnt_t   r_pad_cnt;
    logic [32:0] w_pad_sum;

    assign w_pad_sum = {1'b0, r_pad_cnt} + {1'b0, chnl_cnt_t'(IN) - w_k};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pad_cnt <= '0;
        end else if (w_push) begin
            r_pad_cnt <= w_pad_sum[32] ? '1 : w_pad_sum[31:0];
        end
    end

    assign pad_cnt_o = r_pad_cnt;
`endif

endmodule

// File: tb/tb_chnl_unpacker.sv
// Self-checking bench for chnl_unpacker: word-queue reference model checked
// every cycle, directed scenarios with literal expectations, random messages.
module tb_chnl_unpacker;
    import chnl_pkg::*;

    localparam int IN   = 8;
    localparam int OUT  = 3;
    localparam int W    = 8;
    localparam int LENW = 16;
    localparam int BUFF = IN + OUT - 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              len_val_i;
    logic [LENW-1:0]   len_i;
    logic              len_rdy_o;
    logic              in_val_i;
    logic [W*IN-1:0]   in_data_i;
    logic              in_rdy_o;
    logic              out_val_o;
    logic [W*OUT-1:0]  out_data_o;
    logic              out_last_o;
    logic              out_rdy_i;
    chnl_state_t       dbg_state_o;
`ifdef CHNL_UNPACKER_PAD_CNT_EN
    chnl_cnt_t         pad_cnt_o;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    chnl_unpacker #(
        .IN   (IN),
        .OUT  (OUT),
        .W    (W),
        .LENW (LENW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .len_val_i   (len_val_i),
        .len_i       (len_i),
        .len_rdy_o   (len_rdy_o),
        .in_val_i    (in_val_i),
        .in_data_i   (in_data_i),
        .in_rdy_o    (in_rdy_o),
        .out_val_o   (out_val_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_rdy_i   (out_rdy_i),
        .dbg_state_o (dbg_state_o)
`ifdef CHNL_UNPACKER_PAD_CNT_EN
        ,
        .pad_cnt_o   (pad_cnt_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0]     exp_q[$];
    bit               m_active;
    int               m_beats_left;
    int               m_words_left;
    longint           m_pad;
    logic [W*OUT-1:0] got_q[$];
    bit               got_last[$];
    int               n_pops  = 0;
    int               n_lasts = 0;

    always @(negedge clk_i) begin : compare
        logic [W*OUT-1:0] e_data;
        bit               e_val;
        bit               e_pop;
        bit               e_in_rdy;
        bit               e_last;
        bit               was_active;
        int               k;
        if (rst_i) begin
            exp_q.delete();
            m_active     = 1'b0;
            m_beats_left = 0;
            m_words_left = 0;
            m_pad        = 0;
            check("rst_out_val", out_val_o, 0);
            check("rst_out_last", out_last_o, 0);
            check("rst_out_data", out_data_o, 0);
            check("rst_in_rdy", in_rdy_o, 0);
        end else begin
            e_val    = m_active && (exp_q.size() >= OUT);
            e_pop    = e_val && out_rdy_i;
            e_in_rdy = m_active && (m_words_left > 0) &&
                       (exp_q.size() + IN <= BUFF + (e_pop ? OUT : 0));
            e_last   = e_val && (m_beats_left == 1);
            e_data   = '0;
            for (int i = 0; i < OUT; i++) begin
                if (i < exp_q.size()) e_data[i*W +: W] = exp_q[i];
            end
            check("out_val", out_val_o, e_val);
            check("out_data", out_data_o, e_data);
            check("out_last", out_last_o, e_last);
            check("in_rdy", in_rdy_o, e_in_rdy);
            check("len_rdy", len_rdy_o, !m_active);
            check("dbg_state", dbg_state_o, m_active ? RUN : IDLE);
`ifdef CHNL_UNPACKER_PAD_CNT_EN
            check("pad_cnt", pad_cnt_o, m_pad);
`endif
            if (out_val_o && out_rdy_i) begin
                got_q.push_back(out_data_o);
                got_last.push_back(out_last_o);
                n_pops++;
                if (out_last_o) n_lasts++;
            end
            was_active = m_active;
            if (e_pop) begin
                repeat (OUT) void'(exp_q.pop_front());
                m_beats_left--;
                if (m_beats_left == 0) m_active = 1'b0;
            end
            if (e_in_rdy && in_val_i) begin
                k = (m_words_left < IN) ? m_words_left : IN;
                for (int i = 0; i < k; i++) exp_q.push_back(in_data_i[i*W +: W]);
                m_pad        += IN - k;
                m_words_left -= k;
            end
            if (!was_active && len_val_i && (len_i != 0)) begin
                m_active     = 1'b1;
                m_beats_left = int'(len_i);
                m_words_left = int'(len_i) * OUT;
            end
        end
    end

    // ---------------- drivers ----------------
    int rdy_mode   = 0;  // 0: always ready, 1: random, 2: held low
    bit abort_feed = 1'b0;

    initial begin
        out_rdy_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       out_rdy_i = 1'b1;
                1:       out_rdy_i = ($urandom_range(0, 3) != 0);
                default: out_rdy_i = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_len(input int len, output int waited);
        bit hs;
        len_val_i = 1'b1;
        len_i     = LENW'(len);
        waited    = 0;
        forever begin
            @(negedge clk_i);
            hs = len_rdy_o && !rst_i;
            tick();
            if (hs) break;
            waited++;
            if (waited > 300) begin
                check("len_timeout", 1, 0);
                break;
            end
        end
        len_val_i = 1'b0;
        len_i     = '0;
    endtask

    task automatic feed(input int nbeats, input int base, input bit gaps);
        bit hs;
        int t;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            for (int i = 0; i < IN; i++) in_data_i[i*W +: W] = W'(base + b*IN + i);
            in_val_i = 1'b1;
            t = 0;
            forever begin
                @(negedge clk_i);
                hs = in_rdy_o && !rst_i;
                tick();
                if (hs || abort_feed) break;
                t++;
                if (t > 300) begin
                    check("in_timeout", 1, 0);
                    break;
                end
            end
            in_val_i = 1'b0;
            if (abort_feed) break;
        end
    endtask

    task automatic wait_lasts(input int target);
        int t = 0;
        while (n_lasts < target) begin
            tick();
            t++;
            if (t > 3000) begin
                check("last_timeout", n_lasts, target);
                break;
            end
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        got_last.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int nl;
        int np;
        int len;
        rst_i     = 1'b1;
        len_val_i = 1'b0;
        len_i     = '0;
        in_val_i  = 1'b0;
        in_data_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("len_rdy_after_rst", len_rdy_o, 1);
        check("out_val_after_rst", out_val_o, 0);

        // 1: three full input beats -> eight output beats
        clear_log();
        nl = n_lasts;
        do_len(8, w);
        feed(3, 0, 1'b0);
        wait_lasts(nl + 1);
        check("t1_beats", got_q.size(), 8);
        check("t1_beat0", got_q[0], 24'h020100);
        check("t1_beat7", got_q[7], 24'h171615);
        check("t1_last_on_8th", got_last[7], 1);
        check("t1_no_early_last", got_last[6], 0);
        check("t1_len_rdy", len_rdy_o, 1);

        // 2: padding in the second input beat is discarded
        clear_log();
        nl = n_lasts;
        do_len(3, w);
        feed(2, 0, 1'b0);
        wait_lasts(nl + 1);
        check("t2_beats", got_q.size(), 3);
        check("t2_beat0", got_q[0], 24'h020100);
        check("t2_beat1", got_q[1], 24'h050403);
        check("t2_beat2", got_q[2], 24'h080706);
        check("t2_last", got_last[2], 1);
`ifdef CHNL_UNPACKER_PAD_CNT_EN
        check("t2_pad_cnt", pad_cnt_o, 7);
`endif
        clear_log();
        do_len(1, w);
        feed(1, 'h40, 1'b0);
        wait_lasts(nl + 2);
        check("t2_next_msg_beat0", got_q[0], 24'h424140);

        // 3: zero length is a no-op; next length taken right after
        do_len(0, w);
        repeat (3) tick();
        check("t3_in_rdy", in_rdy_o, 0);
        check("t3_out_val", out_val_o, 0);
        do_len(2, w);
        check("t3_len_next_cycle", w, 0);
        clear_log();
        feed(1, 'h80, 1'b0);
        wait_lasts(nl + 3);
        check("t3_beat1", got_q[1], 24'h858483);

        // 4: output backpressure stalls input after one beat
        clear_log();
        nl = n_lasts;
        rdy_mode = 2;
        do_len(8, w);
        fork
            feed(3, 0, 1'b0);
        join_none
        repeat (10) tick();
        check("t4_out_val_held", out_val_o, 1);
        check("t4_data_held", out_data_o, 24'h020100);
        check("t4_in_rdy_blocked", in_rdy_o, 0);
        rdy_mode = 0;
        wait_lasts(nl + 1);
        wait fork;
        check("t4_beats", got_q.size(), 8);
        check("t4_beat7", got_q[7], 24'h171615);

        // 5: reset in the middle of a message
        clear_log();
        np = n_pops;
        do_len(8, w);
        fork
            feed(3, 0, 1'b1);
        join_none
        w = 0;
        while (n_pops < np + 4 && w < 500) begin
            tick();
            w++;
        end
        check("t5_reached_4_pops", n_pops >= np + 4, 1);
        rst_i      = 1'b1;
        abort_feed = 1'b1;
        #1;
        check("t5_rst_out_val", out_val_o, 0);
        check("t5_rst_out_data", out_data_o, 0);
        check("t5_rst_out_last", out_last_o, 0);
        check("t5_rst_in_rdy", in_rdy_o, 0);
        wait fork;
        in_val_i = 1'b0;
        repeat (2) tick();
        rst_i      = 1'b0;
        abort_feed = 1'b0;
        tick();
        check("t5_len_rdy", len_rdy_o, 1);
        clear_log();
        nl = n_lasts;
        do_len(1, w);
        feed(1, 0, 1'b0);
        wait_lasts(nl + 1);
        check("t5_fresh_beat", got_q[0], 24'h020100);
        check("t5_fresh_last", got_last[0], 1);

        // 6: two length-5 messages with random gaps on both sides
        clear_log();
        nl = n_lasts;
        rdy_mode = 1;
        do_len(5, w);
        feed(2, 'h10, 1'b1);
        do_len(5, w);
        feed(2, 'h30, 1'b1);
        wait_lasts(nl + 2);
        check("t6_beats", got_q.size(), 10);
        check("t6_lasts", got_last[4] + got_last[9], 2);
        check("t6_msg2_beat0", got_q[5], 24'h323130);

        // random messages
        for (int m = 0; m < 8; m++) begin
            rdy_mode = $urandom_range(0, 1);
            len      = $urandom_range(1, 12);
            nl       = n_lasts;
            do_len(len, w);
            feed((len * OUT + IN - 1) / IN, $urandom_range(0, 255), 1'b1);
            wait_lasts(nl + 1);
        end

        rdy_mode = 0;
        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
